// File: rtl/gpio_event_fetcher.sv
// gpio_event_fetcher: reads and clears GPIO RISR/FISR on irq, emits the edge masks as one stream event.
module gpio_event_fetcher #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        irq,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_rising,
  output logic [31:0] evt_falling,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);
  typedef enum logic [3:0] {
    IDLE, RD_R_REQ, RD_R_RSP, RD_F_REQ, RD_F_RSP,
    WR_R_REQ, WR_R_RSP, WR_F_REQ, WR_F_RSP, PUSH, HOLD
  } state_t;
  localparam logic [31:0] RISR_ADDR = BASE_ADDR + 32'h0000_000c;
  localparam logic [31:0] FISR_ADDR = BASE_ADDR + 32'h0000_0014;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic        w_is_req, w_is_rsp, w_hit, w_tmo, w_spur;
  logic        w_req, w_we;
  logic [31:0] w_addr;
  logic        r_req, r_we, r_valid, r_busy, r_err;
  logic [31:0] r_addr, r_rise, r_fall;
  always_comb begin
    w_is_req = r_state inside {RD_R_REQ, RD_F_REQ, WR_R_REQ, WR_F_REQ};
    w_is_rsp = r_state inside {RD_R_RSP, RD_F_RSP, WR_R_RSP, WR_F_RSP};
    w_hit    = w_is_req ? bus_gnt : w_is_rsp ? bus_rvalid : 1'b0;
    w_tmo    = (w_is_req || w_is_rsp) && !w_hit && (r_cnt == CNT_LAST);
    w_spur   = (r_rise == 32'h0) && (bus_rdata == 32'h0);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (enable && irq) ? RD_R_REQ : IDLE;
      RD_F_RSP: w_next = !w_hit ? r_state : w_spur ? HOLD : WR_R_REQ;
      WR_F_RSP: w_next = w_hit ? PUSH : r_state;
      PUSH:     w_next = (r_valid && evt_ready) ? HOLD : PUSH;
      HOLD:     w_next = IDLE;
      default:  w_next = w_hit ? state_t'(r_state + 4'd1) : r_state;
    endcase
    if (w_tmo) w_next = HOLD;
  end
  // Outputs are decoded from the next state so they are registered yet valid in the state's first cycle.
  always_comb begin
    w_req  = w_next inside {RD_R_REQ, RD_F_REQ, WR_R_REQ, WR_F_REQ};
    w_we   = w_next inside {WR_R_REQ, WR_F_REQ};
    w_addr = (w_next inside {RD_R_REQ, WR_R_REQ}) ? RISR_ADDR :
             (w_next inside {RD_F_REQ, WR_F_REQ}) ? FISR_ADDR : r_addr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_cnt   <= (w_next != r_state) ? 16'h0 : (w_is_req || w_is_rsp) ? r_cnt + 16'h1 : r_cnt;
      r_req   <= w_req;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_valid <= (w_next == PUSH);
      r_busy  <= (w_next != IDLE);
      r_err   <= w_tmo || (r_err && !err_clr);
      r_rise  <= (r_state == RD_R_RSP && bus_rvalid) ? bus_rdata : r_rise;
      r_fall  <= (r_state == RD_F_RSP && bus_rvalid) ? bus_rdata : r_fall;
    end
  end
  assign bus_req     = r_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_be      = {4{r_req}};
  assign bus_wdata   = '0;
  assign evt_valid   = r_valid;
  assign evt_rising  = r_rise;
  assign evt_falling = r_fall;
  assign busy        = r_busy;
  assign err         = r_err;
endmodule
